// File: rtl/toe_pkg.sv
// toe_pkg: shared request/error codes and key layout for the TCB lookup engine
package toe_pkg;

    typedef enum logic [1:0] {
        RQ_NOP    = 2'b00,
        RQ_SEARCH = 2'b01,
        RQ_INSERT = 2'b10,
        RQ_DELETE = 2'b11
    } tl_rq_e;

    typedef enum logic [7:0] {
        ERR_OK     = 8'h00,
        ERR_MISS   = 8'h01,
        ERR_FULL   = 8'h02,
        ERR_DUP    = 8'h03,
        ERR_BAD_ID = 8'h04
    } tl_err_e;

    localparam int MAC_W_DEF  = 24;
    localparam int IP_W_DEF   = 32;
    localparam int PORT_W_DEF = 16;

    // Field order matches the concatenation used for the stored key
    typedef struct packed {
        logic [MAC_W_DEF-1:0]  mac_src;
        logic [MAC_W_DEF-1:0]  mac_dst;
        logic [IP_W_DEF-1:0]   ip_src;
        logic [IP_W_DEF-1:0]   ip_dst;
        logic [PORT_W_DEF-1:0] port_src;
        logic [PORT_W_DEF-1:0] port_dst;
    } tcb_key_t;

    localparam int KEY_W = $bits(tcb_key_t);

    function automatic int key_width(input int ip_w, input int mac_w, input int port_w);
        return 2 * (ip_w + mac_w + port_w);
    endfunction

endpackage

// File: rtl/tcb_key_store.sv
// tcb_key_store: DEPTH x KW key flops with valid bits, one write, one read, one clear port
module tcb_key_store #(
    parameter int DEPTH = 16,
    parameter int KW    = 144
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [KW-1:0]              wr_key,
    input  logic                       clr,
    input  logic [$clog2(DEPTH)-1:0]   clr_idx,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [KW-1:0]              rd_key,
    output logic [DEPTH-1:0]           valid
);

    logic [KW-1:0] mem [DEPTH];

    // Key contents are qualified by valid, so they need no reset
    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_key;
    end

    // Valid bits: flush wipes everything, otherwise set on write / clear on delete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (we) valid[wr_idx] <= 1'b1;
            if (clr) valid[clr_idx] <= 1'b0;
        end
    end

    assign rd_key = mem[rd_idx];

endmodule

// File: rtl/tcb_lookup_engine.sv
// tcb_lookup_engine: sequential-scan connection table mapping a TCP 4-tuple key to a TCB id
module tcb_lookup_engine
    import toe_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int IP_W   = 32,
    parameter int MAC_W  = 24,
    parameter int PORT_W = 16
) (
    input  logic                     tl_clk,
    input  logic                     tl_rst,
    input  logic [1:0]               tl_rq,
    input  logic                     tl_flush,
    input  logic [7:0]               tl_id_in,
    input  logic [IP_W-1:0]          tl_ip_src,
    input  logic [IP_W-1:0]          tl_ip_dst,
    input  logic [MAC_W-1:0]         tl_mac_src,
    input  logic [MAC_W-1:0]         tl_mac_dst,
    input  logic [PORT_W-1:0]        tl_port_src,
    input  logic [PORT_W-1:0]        tl_port_dst,
    output logic                     tl_busy,
    output logic                     tl_done,
    output logic [7:0]               tl_error,
    output logic [7:0]               tl_id_out,
    output logic [$clog2(DEPTH):0]   tl_count
);

    localparam int ID_W = $clog2(DEPTH);
    localparam int KW   = key_width(IP_W, MAC_W, PORT_W);

    typedef logic [ID_W-1:0] id_t;
    typedef logic [ID_W:0]   cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_e;

    state_e          state;
    logic [1:0]      op;
    logic [KW-1:0]   lkey;
    id_t             idx;
    id_t             free_idx;
    logic            free_found;
    logic            pend_wr;
    logic            pend_clr;
    logic [KW-1:0]   key_in;
    logic [KW-1:0]   rd_key;
    logic [DEPTH-1:0] valid;
    logic            rd_valid;
    logic            hit;
    logic            last;
    logic            free_now;
    id_t             fidx;
    logic            del_ok;
    logic            we;
    logic            clr;

    assign key_in   = {tl_mac_src, tl_mac_dst, tl_ip_src, tl_ip_dst, tl_port_src, tl_port_dst};
    assign rd_valid = valid[idx];
    assign hit      = rd_valid && rd_key == lkey;
    assign last     = idx == id_t'(DEPTH - 1);
    // A free slot exists if one was seen earlier or the entry under the scan pointer is empty
    assign free_now = free_found || !rd_valid;
    assign fidx     = free_found ? free_idx : idx;
    assign del_ok   = (tl_id_in >> ID_W) == 8'd0 && valid[id_t'(tl_id_in)];
    // Table changes are committed on the edge that leaves RESP, unless flushed
    assign we       = state == S_RESP && pend_wr && !tl_flush;
    assign clr      = state == S_RESP && pend_clr && !tl_flush;

    tcb_key_store #(.DEPTH(DEPTH), .KW(KW)) u_store (
        .clk     (tl_clk),
        .rst_n   (tl_rst),
        .flush   (tl_flush),
        .we      (we),
        .wr_idx  (free_idx),
        .wr_key  (lkey),
        .clr     (clr),
        .clr_idx (id_t'(tl_id_out)),
        .rd_idx  (idx),
        .rd_key  (rd_key),
        .valid   (valid)
    );

    // Control FSM: accept in IDLE, one compare per SCAN cycle, single-cycle RESP with registered result
    always_ff @(posedge tl_clk or negedge tl_rst) begin
        if (!tl_rst) begin
            state      <= S_IDLE;
            op         <= RQ_NOP;
            lkey       <= '0;
            idx        <= '0;
            free_idx   <= '0;
            free_found <= 1'b0;
            pend_wr    <= 1'b0;
            pend_clr   <= 1'b0;
            tl_busy    <= 1'b0;
            tl_done    <= 1'b0;
            tl_error   <= ERR_OK;
            tl_id_out  <= '0;
            tl_count   <= '0;
        end else begin
            tl_done <= 1'b0;
            if (tl_flush) begin
                state    <= S_IDLE;
                tl_busy  <= 1'b0;
                tl_count <= '0;
                pend_wr  <= 1'b0;
                pend_clr <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (tl_rq != RQ_NOP) begin
                        op         <= tl_rq;
                        lkey       <= key_in;
                        idx        <= '0;
                        free_found <= 1'b0;
                        pend_wr    <= 1'b0;
                        tl_busy    <= 1'b1;
                        if (tl_rq == RQ_DELETE) begin
                            state     <= S_RESP;
                            tl_done   <= 1'b1;
                            tl_id_out <= tl_id_in;
                            tl_error  <= del_ok ? ERR_OK : ERR_BAD_ID;
                            pend_clr  <= del_ok;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        idx        <= idx + id_t'(1);
                        free_found <= free_now;
                        free_idx   <= fidx;
                        if (hit || last) begin
                            state     <= S_RESP;
                            tl_done   <= 1'b1;
                            pend_wr   <= op == RQ_INSERT && !hit && free_now;
                            tl_error  <= op == RQ_INSERT ? (hit ? ERR_DUP : free_now ? ERR_OK : ERR_FULL)
                                                         : (hit ? ERR_OK : ERR_MISS);
                            tl_id_out <= hit ? 8'(idx) : (op == RQ_INSERT && free_now) ? 8'(fidx) : 8'd0;
                        end
                    end
                    S_RESP: begin
                        state    <= S_IDLE;
                        tl_busy  <= 1'b0;
                        pend_wr  <= 1'b0;
                        pend_clr <= 1'b0;
                        tl_count <= pend_wr ? tl_count + cnt_t'(1) : pend_clr ? tl_count - cnt_t'(1) : tl_count;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcb_lookup_engine.sv
// tb_tcb_lookup_engine: scoreboard bench with a table-level reference model, DEPTH=4
module tb_tcb_lookup_engine;
    import toe_pkg::*;

    localparam int D = 4;

    logic        tl_clk = 1'b0;
    logic        tl_rst = 1'b0;
    logic [1:0]  tl_rq = RQ_NOP;
    logic        tl_flush = 1'b0;
    logic [7:0]  tl_id_in = '0;
    logic [31:0] tl_ip_src = '0, tl_ip_dst = '0;
    logic [23:0] tl_mac_src = '0, tl_mac_dst = '0;
    logic [15:0] tl_port_src = '0, tl_port_dst = '0;
    logic        tl_busy, tl_done;
    logic [7:0]  tl_error, tl_id_out;
    logic [2:0]  tl_count;

    always #5 tl_clk = ~tl_clk;

    tcb_lookup_engine #(.DEPTH(D), .IP_W(32), .MAC_W(24), .PORT_W(16)) dut (
        .tl_clk      (tl_clk),
        .tl_rst      (tl_rst),
        .tl_rq       (tl_rq),
        .tl_flush    (tl_flush),
        .tl_id_in    (tl_id_in),
        .tl_ip_src   (tl_ip_src),
        .tl_ip_dst   (tl_ip_dst),
        .tl_mac_src  (tl_mac_src),
        .tl_mac_dst  (tl_mac_dst),
        .tl_port_src (tl_port_src),
        .tl_port_dst (tl_port_dst),
        .tl_busy     (tl_busy),
        .tl_done     (tl_done),
        .tl_error    (tl_error),
        .tl_id_out   (tl_id_out),
        .tl_count    (tl_count)
    );

    typedef struct {
        logic [7:0] err;
        logic [7:0] id;
        longint     t;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    tcb_key_t   m_key[D];
    bit         m_val[D];
    int         m_cnt = 0;
    logic [7:0] last_err = 8'h00;
    logic [7:0] last_id = 8'h00;
    tcb_key_t   kp[8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endfunction

    // Table semantics: lowest matching entry wins, lowest empty entry is allocated
    function automatic void model(input logic [1:0] rq, input tcb_key_t k, input logic [7:0] id,
                                  output logic [7:0] err, output logic [7:0] oid, output int lat);
        int hit_at = -1;
        int free_at = -1;
        for (int i = D - 1; i >= 0; i--) begin
            if (m_val[i] && m_key[i] == k) hit_at = i;
            if (!m_val[i]) free_at = i;
        end
        if (rq == RQ_DELETE) begin
            lat = 1;
            oid = id;
            if (id < D && m_val[id]) begin
                err = ERR_OK;
                m_val[id] = 1'b0;
                m_cnt--;
            end else begin
                err = ERR_BAD_ID;
            end
        end else if (hit_at >= 0) begin
            lat = 2 + hit_at;
            oid = 8'(hit_at);
            err = rq == RQ_INSERT ? ERR_DUP : ERR_OK;
        end else begin
            lat = 1 + D;
            oid = 8'h00;
            err = ERR_MISS;
            if (rq == RQ_INSERT) begin
                err = ERR_FULL;
                if (free_at >= 0) begin
                    err = ERR_OK;
                    oid = 8'(free_at);
                    m_key[free_at] = k;
                    m_val[free_at] = 1'b1;
                    m_cnt++;
                end
            end
        end
        last_err = err;
        last_id  = oid;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < D; i++) m_val[i] = 1'b0;
        m_cnt = 0;
    endfunction

    // Monitor: every done must match the oldest expectation, including its arrival time
    always @(negedge tl_clk) begin
        if (tl_rst && tl_done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done err=%0h id=%0h t=%0t", tl_error, tl_id_out, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (tl_error !== e.err || tl_id_out !== e.id || longint'($time) != e.t) begin
                    errors++;
                    $display("FAIL done got err=%0h id=%0h t=%0t want err=%0h id=%0h t=%0d",
                             tl_error, tl_id_out, $time, e.err, e.id, e.t);
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] rq, input tcb_key_t k, input logic [7:0] id, input bit track);
        exp_t e;
        int   lat;
        @(negedge tl_clk);
        tl_rq       = rq;
        tl_id_in    = id;
        tl_mac_src  = k.mac_src;
        tl_mac_dst  = k.mac_dst;
        tl_ip_src   = k.ip_src;
        tl_ip_dst   = k.ip_dst;
        tl_port_src = k.port_src;
        tl_port_dst = k.port_dst;
        @(posedge tl_clk);
        e.t = longint'($time);
        if (track) begin
            model(rq, k, id, e.err, e.id, lat);
            e.t += longint'((lat - 1) * 10 + 5);
            sb.push_back(e);
        end
        #1 tl_rq = RQ_NOP;
    endtask

    task automatic finish_op(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge tl_clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pending=%0d", name, sb.size());
            sb.delete();
        end
        @(negedge tl_clk);
        check({name, "_count"}, 32'(tl_count), 32'(m_cnt));
        check({name, "_busy"}, 32'(tl_busy), 32'd0);
    endtask

    task automatic run(input logic [1:0] rq, input tcb_key_t k, input logic [7:0] id, input string name);
        do_op(rq, k, id, 1'b1);
        finish_op(name);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            kp[i].mac_src  = 24'($urandom);
            kp[i].mac_dst  = 24'($urandom);
            kp[i].ip_src   = $urandom;
            kp[i].ip_dst   = $urandom;
            kp[i].port_src = 16'($urandom);
            kp[i].port_dst = 16'(i);
        end
        model_clear();
        repeat (3) @(negedge tl_clk);
        check("rst_busy", 32'(tl_busy), 32'd0);
        check("rst_done", 32'(tl_done), 32'd0);
        check("rst_error", 32'(tl_error), 32'd0);
        check("rst_id", 32'(tl_id_out), 32'd0);
        check("rst_count", 32'(tl_count), 32'd0);
        tl_rst = 1'b1;

        run(RQ_SEARCH, kp[0], 8'd0, "search_empty");
        run(RQ_INSERT, kp[0], 8'd0, "ins_a");
        run(RQ_INSERT, kp[1], 8'd0, "ins_b");
        run(RQ_INSERT, kp[2], 8'd0, "ins_c");
        run(RQ_INSERT, kp[3], 8'd0, "ins_d");
        run(RQ_INSERT, kp[4], 8'd0, "ins_full");
        run(RQ_INSERT, kp[1], 8'd0, "ins_dup");
        run(RQ_SEARCH, kp[2], 8'd0, "search_c");
        run(RQ_DELETE, kp[0], 8'd1, "del_1");
        run(RQ_INSERT, kp[4], 8'd0, "ins_e");
        run(RQ_DELETE, kp[0], 8'd1, "del_1a");
        run(RQ_DELETE, kp[0], 8'd1, "del_1b");
        run(RQ_DELETE, kp[0], 8'd9, "del_9");

        // Requests pulsed while a long scan is in flight must be dropped
        do_op(RQ_SEARCH, kp[5], 8'd0, 1'b1);
        @(negedge tl_clk);
        tl_rq = RQ_INSERT;
        tl_port_dst = 16'h00aa;
        @(negedge tl_clk);
        tl_rq = RQ_DELETE;
        tl_id_in = 8'd0;
        @(negedge tl_clk);
        tl_rq = RQ_NOP;
        finish_op("busy_ignore");

        // Flush mid-scan: no done, table cleared, result registers hold
        do_op(RQ_SEARCH, kp[2], 8'd0, 1'b0);
        repeat (2) @(negedge tl_clk);
        tl_flush = 1'b1;
        tl_rq = RQ_INSERT;
        @(negedge tl_clk);
        tl_flush = 1'b0;
        tl_rq = RQ_NOP;
        model_clear();
        repeat (8) @(negedge tl_clk);
        check("flush_count", 32'(tl_count), 32'd0);
        check("flush_busy", 32'(tl_busy), 32'd0);
        check("flush_err_hold", 32'(tl_error), 32'(last_err));
        check("flush_id_hold", 32'(tl_id_out), 32'(last_id));
        run(RQ_SEARCH, kp[0], 8'd0, "post_flush_search");

        // Async reset mid-scan
        run(RQ_INSERT, kp[0], 8'd0, "pre_rst_ins");
        do_op(RQ_SEARCH, kp[0], 8'd0, 1'b0);
        @(negedge tl_clk);
        #2 tl_rst = 1'b0;
        @(negedge tl_clk);
        check("arst_busy", 32'(tl_busy), 32'd0);
        check("arst_done", 32'(tl_done), 32'd0);
        tl_rst = 1'b1;
        model_clear();
        repeat (8) @(negedge tl_clk);
        check("arst_count", 32'(tl_count), 32'd0);
        check("arst_error", 32'(tl_error), 32'd0);
        check("arst_id", 32'(tl_id_out), 32'd0);
        run(RQ_SEARCH, kp[0], 8'd0, "post_rst_search");

        for (int i = 0; i < 80; i++) begin
            logic [1:0] rq;
            logic [7:0] id;
            rq = 2'($urandom_range(1, 3));
            id = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) begin
                @(negedge tl_clk);
                tl_flush = 1'b1;
                @(negedge tl_clk);
                tl_flush = 1'b0;
                model_clear();
                check("rand_flush_count", 32'(tl_count), 32'd0);
            end
            run(rq, kp[$urandom_range(0, 5)], id, "rand");
        end

        repeat (3) @(negedge tl_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
